cic_rx_decimator: RTL and testbench

//  Receive-side counterpart of the transmit CIC interpolator: an N-stage CIC decimator for
//  the modem receive/DDC path. Accepts I/Q samples interleaved on one AXI-Stream input
//  (I first, then Q) and emits decimated, gain-normalised I/Q pairs, still interleaved.
//  The decimation rate R is runtime-programmable over a config stream, which uses the same

---
 rtl/cic_rx_decimator.sv | 251 +++++++++++++++++++++++++
 tb/tb_cic_rx_decimator.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cic_rx_decimator.sv
// rtl/cic_rx_decimator.sv - N-stage CIC decimator for interleaved I/Q receive samples
//
// Purpose:
//   Decimates an I/Q-interleaved sample stream (I beat first, then Q beat) by a
//   runtime-programmable rate R and emits gain-normalised I/Q pairs, still
//   interleaved, through a small output FIFO. Frame ends (tlast) are carried
//   through to the Q word of the next output pair, and tuser numbers the output
//   pairs within a frame.
//
// Ports:
//   aclk, areset                 clock, asynchronous active-high reset
//   S_AXIS_CONFIG_tdata/tvalid   16-bit decimation rate word (clamped to 2..R_MAX)
//   S_AXIS_CONFIG_tready         config accepted when high with tvalid
//   S_AXIS_tdata/tvalid/tlast    input samples, I/Q interleaved; tlast sampled on Q beats
//   S_AXIS_tready                input ready
//   M_AXIS_tdata/tvalid/tlast    decimated samples, I then Q; tlast on the Q word only
//   M_AXIS_tready                downstream ready
//   M_AXIS_tuser                 0-based index of the output pair within its frame
module cic_rx_decimator #(
    parameter int IN_W     = 16,
    parameter int OUT_W    = 16,
    parameter int N_STAGES = 4,
    parameter int R_MAX    = 64,
    parameter int FIFO_D   = 4
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic [15:0]      S_AXIS_CONFIG_tdata,
    input  logic             S_AXIS_CONFIG_tvalid,
    output logic             S_AXIS_CONFIG_tready,
    input  logic [IN_W-1:0]  S_AXIS_tdata,
    input  logic             S_AXIS_tvalid,
    output logic             S_AXIS_tready,
    input  logic             S_AXIS_tlast,
    output logic [OUT_W-1:0] M_AXIS_tdata,
    output logic             M_AXIS_tvalid,
    input  logic             M_AXIS_tready,
    output logic             M_AXIS_tlast,
    output logic [15:0]      M_AXIS_tuser
);

    localparam int ACC_W   = IN_W + N_STAGES * $clog2(R_MAX);
    localparam int RATE_W  = $clog2(R_MAX) + 1;
    localparam int SHIFT_W = $clog2(ACC_W);
    localparam int PTR_W   = $clog2(FIFO_D);

    typedef enum logic [2:0] {
        S_UNCFG,
        S_CLEAR,
        S_WAIT_I,
        S_WAIT_Q,
        S_COMB_I,
        S_COMB_Q
    } state_t;

    state_t r_state, w_state_nxt;

    logic [RATE_W-1:0]  r_rate;
    logic [SHIFT_W-1:0] r_shift;
    logic [RATE_W-1:0]  r_dec_cnt;
    logic [15:0]        r_tuser;
    logic               r_last_flag;

    logic [ACC_W-1:0] r_int_i [N_STAGES];
    logic [ACC_W-1:0] r_int_q [N_STAGES];
    logic [ACC_W-1:0] r_dly_i [N_STAGES];
    logic [ACC_W-1:0] r_dly_q [N_STAGES];

    logic [OUT_W-1:0] r_fifo_data [FIFO_D];
    logic             r_fifo_last [FIFO_D];
    logic [15:0]      r_fifo_user [FIFO_D];
    logic [PTR_W:0]   r_wptr, r_rptr;

    logic [ACC_W-1:0]   w_in_ext;
    logic [ACC_W-1:0]   w_int_cur [N_STAGES];
    logic [ACC_W-1:0]   w_int_nxt [N_STAGES];
    logic [ACC_W-1:0]   w_dly_cur [N_STAGES];
    logic [ACC_W-1:0]   w_comb    [N_STAGES+1];
    logic [OUT_W-1:0]   w_out_word;
    logic [PTR_W:0]     w_count;
    logic               w_cfg_hs, w_s_hs, w_pop, w_push, w_dec_wrap;
    logic [RATE_W-1:0]  w_rate_new;
    logic [SHIFT_W-1:0] w_shift_new;

    function automatic logic [RATE_W-1:0] f_clamp(input logic [15:0] v);
        if (v < 16'd2)
            return RATE_W'(2);
        else if (v > 16'(R_MAX))
            return RATE_W'(R_MAX);
        else
            return v[RATE_W-1:0];
    endfunction

    // N * ceil(log2(r)): the normalising shift that keeps R^N / 2^shift <= 1.
    function automatic logic [SHIFT_W-1:0] f_shift(input logic [RATE_W-1:0] r);
        logic [RATE_W-1:0]  t;
        logic [SHIFT_W-1:0] lg;
        t  = r - RATE_W'(1);
        lg = '0;
        for (int b = 0; b < RATE_W; b++) begin
            if (t[b]) lg = SHIFT_W'(b + 1);
        end
        return SHIFT_W'(N_STAGES) * lg;
    endfunction

    assign w_rate_new  = f_clamp(S_AXIS_CONFIG_tdata);
    assign w_shift_new = f_shift(w_rate_new);

    // Gated by reset so every output reads 0 while areset is held.
    assign S_AXIS_CONFIG_tready = !areset && (r_state == S_UNCFG || r_state == S_WAIT_I);
    assign S_AXIS_tready = (r_state == S_WAIT_Q) ||
                           (r_state == S_WAIT_I && w_count <= (PTR_W+1)'(FIFO_D - 2));

    assign w_cfg_hs   = S_AXIS_CONFIG_tvalid && S_AXIS_CONFIG_tready;
    assign w_s_hs     = S_AXIS_tvalid && S_AXIS_tready;
    assign w_dec_wrap = (r_dec_cnt == r_rate - RATE_W'(1));

    assign w_count       = r_wptr - r_rptr;
    assign M_AXIS_tvalid = (w_count != '0);
    assign M_AXIS_tdata  = r_fifo_data[r_rptr[PTR_W-1:0]];
    assign M_AXIS_tlast  = r_fifo_last[r_rptr[PTR_W-1:0]];
    assign M_AXIS_tuser  = r_fifo_user[r_rptr[PTR_W-1:0]];
    assign w_pop         = M_AXIS_tvalid && M_AXIS_tready;
    assign w_push        = (r_state == S_COMB_I) || (r_state == S_COMB_Q);

    assign w_in_ext = {{(ACC_W-IN_W){S_AXIS_tdata[IN_W-1]}}, S_AXIS_tdata};

    // One integrator chain serves both channels; the state selects which
    // channel's registers feed it. Each stage adds the freshly updated value of
    // the stage before it, so the whole chain settles in one cycle.
    always_comb begin
        for (int k = 0; k < N_STAGES; k++) begin
            w_int_cur[k] = (r_state == S_WAIT_Q) ? r_int_q[k] : r_int_i[k];
        end
        w_int_nxt[0] = w_int_cur[0] + w_in_ext;
        for (int k = 1; k < N_STAGES; k++) begin
            w_int_nxt[k] = w_int_cur[k] + w_int_nxt[k-1];
        end
    end

    // Comb chain, also shared: c_{k+1} = c_k - delay_k, delay_k then takes c_k.
    always_comb begin
        w_comb[0] = (r_state == S_COMB_Q) ? r_int_q[N_STAGES-1] : r_int_i[N_STAGES-1];
        for (int k = 0; k < N_STAGES; k++) begin
            w_dly_cur[k]  = (r_state == S_COMB_Q) ? r_dly_q[k] : r_dly_i[k];
            w_comb[k+1]   = w_comb[k] - w_dly_cur[k];
        end
    end

    assign w_out_word = w_comb[N_STAGES][r_shift +: OUT_W];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_UNCFG:  if (w_cfg_hs) w_state_nxt = S_CLEAR;
            S_CLEAR:  w_state_nxt = S_WAIT_I;
            S_WAIT_I: begin
                // A config beat wins over a simultaneous I beat; that sample is
                // flushed along with the rest of the pipeline.
                if (w_cfg_hs)    w_state_nxt = S_CLEAR;
                else if (w_s_hs) w_state_nxt = S_WAIT_Q;
            end
            S_WAIT_Q: if (w_s_hs) w_state_nxt = w_dec_wrap ? S_COMB_I : S_WAIT_I;
            S_COMB_I: w_state_nxt = S_COMB_Q;
            S_COMB_Q: w_state_nxt = S_WAIT_I;
            default:  w_state_nxt = S_UNCFG;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) r_state <= S_UNCFG;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_rate      <= '0;
            r_shift     <= '0;
            r_dec_cnt   <= '0;
            r_tuser     <= '0;
            r_last_flag <= 1'b0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            for (int k = 0; k < N_STAGES; k++) begin
                r_int_i[k] <= '0;
                r_int_q[k] <= '0;
                r_dly_i[k] <= '0;
                r_dly_q[k] <= '0;
            end
            for (int j = 0; j < FIFO_D; j++) begin
                r_fifo_data[j] <= '0;
                r_fifo_last[j] <= 1'b0;
                r_fifo_user[j] <= '0;
            end
        end else begin
            if (w_cfg_hs) begin
                r_rate  <= w_rate_new;
                r_shift <= w_shift_new;
            end

            if (r_state == S_CLEAR) begin
                r_dec_cnt   <= '0;
                r_tuser     <= '0;
                r_last_flag <= 1'b0;
                r_wptr      <= '0;
                r_rptr      <= '0;
                for (int k = 0; k < N_STAGES; k++) begin
                    r_int_i[k] <= '0;
                    r_int_q[k] <= '0;
                    r_dly_i[k] <= '0;
                    r_dly_q[k] <= '0;
                end
                for (int j = 0; j < FIFO_D; j++) begin
                    r_fifo_data[j] <= '0;
                    r_fifo_last[j] <= 1'b0;
                    r_fifo_user[j] <= '0;
                end
            end else begin
                if (r_state == S_WAIT_I && w_s_hs && !w_cfg_hs) begin
                    for (int k = 0; k < N_STAGES; k++) r_int_i[k] <= w_int_nxt[k];
                end

                if (r_state == S_WAIT_Q && w_s_hs) begin
                    for (int k = 0; k < N_STAGES; k++) r_int_q[k] <= w_int_nxt[k];
                    r_dec_cnt <= w_dec_wrap ? '0 : r_dec_cnt + RATE_W'(1);
                    if (S_AXIS_tlast) r_last_flag <= 1'b1;
                end

                if (r_state == S_COMB_I) begin
                    for (int k = 0; k < N_STAGES; k++) r_dly_i[k] <= w_comb[k];
                end

                if (r_state == S_COMB_Q) begin
                    for (int k = 0; k < N_STAGES; k++) r_dly_q[k] <= w_comb[k];
                    r_last_flag <= 1'b0;
                    r_tuser     <= r_last_flag ? 16'd0 : r_tuser + 16'd1;
                end

                if (w_push) begin
                    r_fifo_data[r_wptr[PTR_W-1:0]] <= w_out_word;
                    r_fifo_last[r_wptr[PTR_W-1:0]] <= (r_state == S_COMB_Q) && r_last_flag;
                    r_fifo_user[r_wptr[PTR_W-1:0]] <= r_tuser;
                    r_wptr <= r_wptr + (PTR_W+1)'(1);
                end

                if (w_pop) r_rptr <= r_rptr + (PTR_W+1)'(1);
            end
        end
    end

endmodule

// File: tb/tb_cic_rx_decimator.sv
// tb/tb_cic_rx_decimator.sv - directed-vector bench for cic_rx_decimator
module tb_cic_rx_decimator;

    logic        aclk = 1'b0;
    logic        areset;
    logic [15:0] cfg_tdata;
    logic        cfg_tvalid;
    logic        cfg_tready;
    logic [15:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic        s_tlast;
    logic [15:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic [15:0] m_tuser;

    always #5 aclk = ~aclk;

    cic_rx_decimator dut (
        .aclk                 (aclk),
        .areset               (areset),
        .S_AXIS_CONFIG_tdata  (cfg_tdata),
        .S_AXIS_CONFIG_tvalid (cfg_tvalid),
        .S_AXIS_CONFIG_tready (cfg_tready),
        .S_AXIS_tdata         (s_tdata),
        .S_AXIS_tvalid        (s_tvalid),
        .S_AXIS_tready        (s_tready),
        .S_AXIS_tlast         (s_tlast),
        .M_AXIS_tdata         (m_tdata),
        .M_AXIS_tvalid        (m_tvalid),
        .M_AXIS_tready        (m_tready),
        .M_AXIS_tlast         (m_tlast),
        .M_AXIS_tuser         (m_tuser)
    );

    typedef struct {
        int cfg;
        int rate;
        int iv;
        int qv;
        int nout;
        int from;
        int exp_i;
        int exp_q;
    } vec_t;

    typedef struct {
        int data;
        int last;
        int user;
    } word_t;

    vec_t  vecs [5];
    word_t mon_q [$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    trans_exp [8];

    always @(negedge aclk) begin
        word_t w;
        if (!areset && m_tvalid && m_tready) begin
            w.data = int'($signed(m_tdata));
            w.last = int'(m_tlast);
            w.user = int'(m_tuser);
            mon_q.push_back(w);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_beat(input int d, input bit last);
        bit ok;
        s_tdata  = d[15:0];
        s_tvalid = 1'b1;
        s_tlast  = last;
        ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge aclk);
            if (s_tready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            @(posedge aclk);
            #1;
        end else begin
            chk("beat_timeout", 0, 1);
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic send_pair(input int i, input int q, input bit last);
        do_beat(i, 1'b0);
        do_beat(q, last);
    endtask

    task automatic configure(input int v);
        bit ok;
        cfg_tdata  = v[15:0];
        cfg_tvalid = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge aclk);
            if (cfg_tready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            @(posedge aclk);
            #1;
        end else begin
            chk("cfg_timeout", 0, 1);
        end
        cfg_tvalid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_m_tvalid"}, int'(m_tvalid), 0);
        chk({tag, "_m_tdata"}, int'(m_tdata), 0);
        chk({tag, "_m_tlast"}, int'(m_tlast), 0);
        chk({tag, "_m_tuser"}, int'(m_tuser), 0);
        chk({tag, "_s_tready"}, int'(s_tready), 0);
        chk({tag, "_cfg_tready"}, int'(cfg_tready), 0);
    endtask

    task automatic do_reset();
        @(posedge aclk);
        #1;
        areset = 1'b1;
        @(posedge aclk);
        #1;
        areset = 1'b0;
        mon_q.delete();
    endtask

    // R=2 from zeroed state, DC I=1000 / Q=-1000: response taps (1+z^-1)^4,
    // so outputs are 1000*{5,15,16,16}/16 floored.
    task automatic check_transient(input string tag);
        chk({tag, "_count"}, mon_q.size(), 8);
        for (int k = 0; k < 8; k++) begin
            if (k < mon_q.size()) begin
                chk($sformatf("%s_data%0d", tag, k), mon_q[k].data, trans_exp[k]);
                chk($sformatf("%s_user%0d", tag, k), mon_q[k].user, k / 2);
                chk($sformatf("%s_last%0d", tag, k), mon_q[k].last, 0);
            end
        end
    endtask

    initial begin
        int stuck_ready;
        int head_changes;
        int head0;
        int exp_user [8];

        trans_exp = '{312, -313, 937, -938, 1000, -1000, 1000, -1000};
        vecs[0] = '{32,  32, 1000,   -1000, 20, 4, 1000,   -1000};
        vecs[1] = '{40,  40, 1000,   -1000,  6, 4,  152,    -153};
        vecs[2] = '{1,    2, 1000,   -1000, 10, 3, 1000,   -1000};
        vecs[3] = '{500, 64, 1000,   -1000,  6, 4, 1000,   -1000};
        vecs[4] = '{16,  16, -32768, 32767,  6, 4, -32768, 32767};

        areset     = 1'b1;
        cfg_tdata  = '0;
        cfg_tvalid = 1'b0;
        s_tdata    = '0;
        s_tvalid   = 1'b0;
        s_tlast    = 1'b0;
        m_tready   = 1'b1;

        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check_zero_outputs("reset");
        @(posedge aclk);
        #1;
        areset = 1'b0;
        @(negedge aclk);
        chk("uncfg_cfg_tready", int'(cfg_tready), 1);
        chk("uncfg_s_tready", int'(s_tready), 0);
        @(posedge aclk);
        #1;

        for (int v = 0; v < 5; v++) begin
            do_reset();
            configure(vecs[v].cfg);
            for (int p = 0; p < vecs[v].nout * vecs[v].rate; p++)
                send_pair(vecs[v].iv, vecs[v].qv, 1'b0);
            idle(10);
            chk($sformatf("v%0d_count", v), mon_q.size(), 2 * vecs[v].nout);
            for (int k = 0; k < vecs[v].nout; k++) begin
                if (2 * k + 1 < mon_q.size()) begin
                    chk($sformatf("v%0d_user_i%0d", v, k), mon_q[2*k].user, k);
                    chk($sformatf("v%0d_user_q%0d", v, k), mon_q[2*k+1].user, k);
                    chk($sformatf("v%0d_last_q%0d", v, k), mon_q[2*k+1].last, 0);
                    if (k >= vecs[v].from) begin
                        chk($sformatf("v%0d_i%0d", v, k), mon_q[2*k].data, vecs[v].exp_i);
                        chk($sformatf("v%0d_q%0d", v, k), mon_q[2*k+1].data, vecs[v].exp_q);
                    end
                end
            end
        end

        // Backpressure: two output pairs fill the 4-word FIFO, the next I beat stalls.
        do_reset();
        configure(2);
        m_tready = 1'b0;
        for (int p = 0; p < 4; p++) send_pair(1000, -1000, 1'b0);
        idle(4);
        @(negedge aclk);
        chk("bp_m_tvalid", int'(m_tvalid), 1);
        chk("bp_head", int'($signed(m_tdata)), 312);
        head0 = int'($signed(m_tdata));
        s_tdata  = 16'd1000;
        s_tvalid = 1'b1;
        stuck_ready  = 0;
        head_changes = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge aclk);
            if (s_tready) stuck_ready++;
            if (int'($signed(m_tdata)) != head0 || !m_tvalid) head_changes++;
        end
        chk("bp_s_tready_held_low", stuck_ready, 0);
        chk("bp_head_stable", head_changes, 0);
        @(posedge aclk);
        #1;
        m_tready = 1'b1;
        do_beat(1000, 1'b0);
        do_beat(-1000, 1'b0);
        send_pair(1000, -1000, 1'b0);
        send_pair(1000, -1000, 1'b0);
        send_pair(1000, -1000, 1'b0);
        idle(10);
        check_transient("bp");

        // Frame end on the Q beat of pair 100 at R=40 lands in output pair 2.
        do_reset();
        configure(40);
        for (int p = 0; p < 160; p++) send_pair(1000, -1000, p == 100);
        idle(10);
        exp_user = '{0, 0, 1, 1, 2, 2, 0, 0};
        chk("tl_count", mon_q.size(), 8);
        for (int k = 0; k < 8; k++) begin
            if (k < mon_q.size()) begin
                chk($sformatf("tl_user%0d", k), mon_q[k].user, exp_user[k]);
                chk($sformatf("tl_last%0d", k), mon_q[k].last, (k == 5) ? 1 : 0);
            end
        end
        if (mon_q.size() == 8) begin
            chk("tl_i3", mon_q[6].data, 152);
            chk("tl_q3", mon_q[7].data, -153);
        end

        // Reset in the middle of a pair, then a clean restart from zero state.
        do_reset();
        configure(32);
        for (int p = 0; p < 50; p++) send_pair(1000, -1000, 1'b0);
        do_beat(1000, 1'b0);
        areset = 1'b1;
        @(negedge aclk);
        check_zero_outputs("midrst");
        @(posedge aclk);
        #1;
        areset = 1'b0;
        @(negedge aclk);
        chk("midrst_cfg_tready", int'(cfg_tready), 1);
        chk("midrst_s_tready", int'(s_tready), 0);
        @(posedge aclk);
        #1;
        mon_q.delete();
        configure(1);
        for (int p = 0; p < 8; p++) send_pair(1000, -1000, 1'b0);
        idle(10);
        check_transient("midrst");

        // New config while the FIFO holds unsent words: they are dropped.
        m_tready = 1'b0;
        for (int p = 0; p < 4; p++) send_pair(500, -500, 1'b0);
        idle(4);
        @(negedge aclk);
        chk("recfg_full_tvalid", int'(m_tvalid), 1);
        @(posedge aclk);
        #1;
        configure(2);
        idle(2);
        @(negedge aclk);
        chk("recfg_flushed_tvalid", int'(m_tvalid), 0);
        @(posedge aclk);
        #1;
        mon_q.delete();
        m_tready = 1'b1;
        for (int p = 0; p < 8; p++) send_pair(1000, -1000, 1'b0);
        idle(10);
        check_transient("recfg");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
